// File: rtl/fp_div_seq.sv
// Iterative IEEE-754 single-precision divider (res = a / b): restoring radix-2
// significand divide, fixed 27-cycle start-to-done latency, truncating.
module fp_div_seq #(
    parameter int QBITS = 25
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic        exception,
    output logic        overflow,
    output logic        underflow,
    output logic [31:0] res
);
    typedef enum logic [1:0] {S_IDLE, S_DIV, S_NORM, S_DONE} state_t;

    state_t             r_state;
    logic [31:0]        r_a, r_b;
    logic [25:0]        r_rem;
    logic [QBITS-1:0]   r_q;
    logic [4:0]         r_cnt;

    logic [23:0]        w_sig_a_in, w_sig_b;
    logic [25:0]        w_rem_sub;
    logic               w_ge;
    logic               w_sign;
    logic signed [9:0]  w_e;
    logic [22:0]        w_mant;

    assign w_sig_a_in = (a[30:23] != 8'h00) ? {1'b1, a[22:0]} : 24'h0;
    assign w_sig_b    = (r_b[30:23] != 8'h00) ? {1'b1, r_b[22:0]} : 24'h0;
    assign w_ge       = r_rem >= {2'b00, w_sig_b};
    assign w_rem_sub  = r_rem - {2'b00, w_sig_b};

    // Quotient lies in [2^23, 2^25); q[24] selects which bit is the hidden one.
    assign w_sign = r_a[31] ^ r_b[31];
    assign w_e    = $signed({2'b00, r_a[30:23]}) - $signed({2'b00, r_b[30:23]})
                  + (r_q[24] ? 10'sd127 : 10'sd126);
    assign w_mant = r_q[24] ? r_q[23:1] : r_q[22:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_a       <= 32'h0;
            r_b       <= 32'h0;
            r_rem     <= 26'h0;
            r_q       <= '0;
            r_cnt     <= 5'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            exception <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            res       <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_rem   <= {2'b00, w_sig_a_in};
                        r_cnt   <= 5'd0;
                        busy    <= 1'b1;
                        r_state <= S_DIV;
                    end
                end
                S_DIV: begin
                    if (w_ge) begin
                        r_q   <= {r_q[QBITS-2:0], 1'b1};
                        r_rem <= {w_rem_sub[24:0], 1'b0};
                    end else begin
                        r_q   <= {r_q[QBITS-2:0], 1'b0};
                        r_rem <= {r_rem[24:0], 1'b0};
                    end
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'(QBITS - 1)) r_state <= S_NORM;
                end
                S_NORM: begin
                    exception <= 1'b0;
                    overflow  <= 1'b0;
                    underflow <= 1'b0;
                    if (r_a[30:23] == 8'hFF || r_b[30:23] == 8'hFF || r_b[30:23] == 8'h00) begin
                        res       <= {w_sign, 8'hFF, 23'h0};
                        exception <= 1'b1;
                        overflow  <= 1'b1;
                    end else if (r_a[30:23] == 8'h00) begin
                        res <= 32'h0;
                    end else if (w_e >= 10'sd255) begin
                        res      <= {w_sign, 8'hFF, 23'h0};
                        overflow <= 1'b1;
                    end else if (w_e <= 10'sd0) begin
                        res       <= 32'h0;
                        underflow <= 1'b1;
                    end else begin
                        res <= {w_sign, w_e[7:0], w_mant};
                    end
                    done    <= 1'b1;
                    r_state <= S_DONE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fp_div_seq.sv
// Scoreboard bench for fp_div_seq: directed operand pairs with hand-computed
// results, latency tracked against a free-running cycle counter.
module tb_fp_div_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a = 32'h0, b = 32'h0;
    logic        busy, done, exception, overflow, underflow;
    logic [31:0] res;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  flg;
        int          dcyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic prev_done = 1'b0;

    fp_div_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .exception(exception), .overflow(overflow),
        .underflow(underflow), .res(res)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cyc %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse pops one expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                if (prev_done) chk("done_width", 32'd1, 32'd0);
                chk("busy_at_done", {31'h0, busy}, 32'd1);
                if (sb.size() == 0) begin
                    chk("spurious_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("res", res, e.res);
                    chk("flags", {29'h0, exception, overflow, underflow}, {29'h0, e.flg});
                    chk("latency", 32'(cyc), 32'(e.dcyc));
                end
            end
            prev_done = done;
        end
    end

    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic push,
                         input logic [31:0] eres, input logic [2:0] eflg);
        exp_t e;
        @(negedge clk);
        a = ia; b = ib; start = 1'b1;
        if (push) begin
            e.res = eres; e.flg = eflg; e.dcyc = cyc + 27;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic chk_zero(input string name);
        chk(name, {busy, done, exception, overflow, underflow, res[26:0]}, 32'h0);
        chk({name, "_res"}, res, 32'h0);
    endtask

    initial begin
        exp_t e;
        int   c;
        #1 chk_zero("reset_state");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // flags are {exception, overflow, underflow}
        issue(32'h40C0_0000, 32'h4000_0000, 1, 32'h4040_0000, 3'b000); drain();
        issue(32'h3F80_0000, 32'h4040_0000, 1, 32'h3EAA_AAAA, 3'b000); drain();
        issue(32'hC120_0000, 32'h4080_0000, 1, 32'hC020_0000, 3'b000); drain();
        issue(32'h3F80_0000, 32'h0000_0000, 1, 32'h7F80_0000, 3'b110); drain();
        issue(32'h7F80_0000, 32'h7F80_0000, 1, 32'h7F80_0000, 3'b110); drain();
        issue(32'h0000_0000, 32'hC152_6666, 1, 32'h0000_0000, 3'b000); drain();
        issue(32'h7F00_0000, 32'h3E80_0000, 1, 32'h7F80_0000, 3'b010); drain();
        issue(32'h0080_0000, 32'h4B00_0000, 1, 32'h0000_0000, 3'b001); drain();

        // A start pulse while busy must not launch a second operation.
        issue(32'h40C0_0000, 32'h4000_0000, 1, 32'h4040_0000, 3'b000);
        repeat (5) @(negedge clk);
        a = 32'h3F80_0000; b = 32'h0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (40) @(negedge clk);

        // Start held high; operands swapped right after accept.
        @(negedge clk);
        c = cyc;
        a = 32'hC120_0000; b = 32'h4080_0000; start = 1'b1;
        e.res = 32'hC020_0000; e.flg = 3'b000; e.dcyc = c + 27; sb.push_back(e);
        e.res = 32'h3EAA_AAAA; e.flg = 3'b000; e.dcyc = c + 55; sb.push_back(e);
        @(negedge clk);
        a = 32'h3F80_0000; b = 32'h4040_0000;
        while (cyc < c + 29) @(negedge clk);
        start = 1'b0;
        drain();
        repeat (3) @(negedge clk);

        // Reset mid-division: everything clears at once, no done follows.
        issue(32'h40C0_0000, 32'h4000_0000, 0, 32'h0, 3'b000);
        repeat (9) @(negedge clk);
        chk("busy_before_reset", {31'h0, busy}, 32'd1);
        rst_n = 1'b0;
        #1 chk_zero("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        issue(32'h3F80_0000, 32'h4040_0000, 1, 32'h3EAA_AAAA, 3'b000); drain();
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
